fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/gfx_pkg.sv | 22 ++
 rtl/index_fifo.sv | 65 ++++++
 rtl/fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics types: ROM index entry layout, terminator marker and sequencer states.
package gfx_pkg;

  localparam logic [11:0] TERMINATOR_ID = 12'hFFF;

  typedef struct packed {
    logic [11:0] vertex_id;
    logic [11:0] material_id;
  } index_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  function automatic logic is_terminator(input index_entry_t entry);
    return entry.vertex_id == TERMINATOR_ID;
  endfunction

endpackage

// File: rtl/index_fifo.sv
// Synchronous FIFO of index entries with a registered head word, valid flag and occupancy.
module index_fifo
  import gfx_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               push,
  input  index_entry_t       push_data,
  input  logic               pop,
  output logic               valid,
  output index_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  index_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_inc;
  logic [CNT_W-1:0] count_reg, count_next;
  index_entry_t     head_reg, head_next;
  logic             valid_reg;
  logic             do_push, do_pop;

  assign do_pop     = pop && valid_reg;
  assign do_push    = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
  assign count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // The head register is loaded straight from the push port when the entry
  // lands in an empty (or emptying) buffer, otherwise from the next stored slot.
  always_comb begin
    head_next = head_reg;
    if (do_push && ((count_reg == '0) || ((count_reg == CNT_W'(1)) && do_pop)))
      head_next = push_data;
    else if (do_pop && (count_reg > CNT_W'(1)))
      head_next = mem[rd_ptr_inc];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      head_reg  <= head_next;
      valid_reg <= (count_next != '0);
    end
  end

  assign valid = valid_reg;
  assign head  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Draw-call index fetch: issues count ROM reads from base and buffers returns in index_fifo.
// Optional macro FETCH_SEQ_TERMINATOR_EN: a returned TERMINATOR_ID vertex ends the draw early.
module fetch_sequencer
  import gfx_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic [ADDR_WIDTH:0]   count_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [ADDR_WIDTH-1:0] rom_addr_out,
  output logic                  rom_rd_out,
  input  logic [23:0]           rom_data_in,
  output logic                  index_valid_out,
  input  logic                  index_ready_in,
  output logic [11:0]           vertex_id_out,
  output logic [11:0]           material_out
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = $clog2(FIFO_DEPTH) + 2;

  seq_state_t            state_reg, state_next;
  logic [CNT_W-1:0]      remaining_reg, remaining_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  rd_reg, rd_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  discard_reg, discard_next;
  logic [SUM_W-1:0]      inflight_reg, inflight_next;
  logic [LATENCY-1:0]    ret_pipe_reg, ret_pipe_next;

  index_entry_t          ret_entry, fifo_head;
  logic [OCC_W-1:0]      fifo_count;
  logic                  fifo_valid, ret_valid, term_hit, push, pop, has_room;
  logic [SUM_W-1:0]      occ_next;

  // Return tracker: bit k set means a read issued k+1 cycles ago is still due.
  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_ret_pipe
      if (gi == 0) begin : g_first
        assign ret_pipe_next[gi] = rd_reg;
      end else begin : g_rest
        assign ret_pipe_next[gi] = ret_pipe_reg[gi-1];
      end
    end
  endgenerate

  assign ret_valid = ret_pipe_reg[LATENCY-1];
  assign ret_entry = index_entry_t'(rom_data_in);

`ifdef FETCH_SEQ_TERMINATOR_EN
  assign term_hit = ret_valid && !discard_reg && is_terminator(ret_entry);
`else
  assign term_hit = 1'b0;
`endif

  assign push          = ret_valid && !discard_reg && !term_hit;
  assign pop           = fifo_valid && index_ready_in;
  assign occ_next      = SUM_W'(fifo_count) + SUM_W'(push) - SUM_W'(pop);
  assign inflight_next = inflight_reg + SUM_W'(rd_reg) - SUM_W'(ret_valid);
  // Credit check uses next-cycle occupancy so a read issued next cycle always has a slot.
  assign has_room      = (occ_next + inflight_next) < SUM_W'(FIFO_DEPTH);

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    addr_next      = rd_reg ? addr_reg + ADDR_WIDTH'(1) : addr_reg;
    discard_next   = discard_reg;
    rd_next        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        discard_next = 1'b0;
        if (start_in) begin
          remaining_next = count_in;
          addr_next      = base_in;
          if (count_in == '0) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_ISSUE;
            rd_next    = has_room;
          end
        end
      end
      ST_ISSUE: begin
        remaining_next = remaining_reg - CNT_W'(rd_reg);
        if (term_hit) begin
          state_next   = ST_DRAIN;
          discard_next = 1'b1;
        end else if (remaining_next == '0) begin
          state_next = ST_DRAIN;
        end else begin
          rd_next = has_room;
        end
      end
      ST_DRAIN: begin
        if (term_hit) discard_next = 1'b1;
        if ((occ_next == '0) && (inflight_next == '0)) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next   = ST_IDLE;
        discard_next = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_next = (state_next == ST_ISSUE) || (state_next == ST_DRAIN);
  assign done_next = (state_next == ST_DONE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      addr_reg      <= '0;
      rd_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      discard_reg   <= 1'b0;
      inflight_reg  <= '0;
      ret_pipe_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      addr_reg      <= addr_next;
      rd_reg        <= rd_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      discard_reg   <= discard_next;
      inflight_reg  <= inflight_next;
      ret_pipe_reg  <= ret_pipe_next;
    end
  end

  index_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_index_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (push),
    .push_data(ret_entry),
    .pop      (pop),
    .valid    (fifo_valid),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign busy_out        = busy_reg;
  assign done_out        = done_reg;
  assign rom_addr_out    = addr_reg;
  assign rom_rd_out      = rd_reg;
  assign index_valid_out = fifo_valid;
  assign vertex_id_out   = fifo_head.vertex_id;
  assign material_out    = fifo_head.material_id;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed draw table, reset-mid-draw sequence and random draws vs a ROM-walk model.
module tb_fetch_sequencer;
  import gfx_pkg::*;

  localparam int AW     = 10;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;
  localparam int DC     = -2;
  localparam int NEVER  = 1 << 30;
  localparam int BUDGET = 3000;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [AW-1:0] base_in;
  logic [AW:0]   count_in;
  logic          busy_out, done_out;
  logic [AW-1:0] rom_addr_out;
  logic          rom_rd_out;
  logic [23:0]   rom_data_in;
  logic          index_valid_out, index_ready_in;
  logic [11:0]   vertex_id_out, material_out;

  always #5 clk_in = ~clk_in;

  fetch_sequencer #(.ADDR_WIDTH(AW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .base_in(base_in),
    .count_in(count_in), .busy_out(busy_out), .done_out(done_out),
    .rom_addr_out(rom_addr_out), .rom_rd_out(rom_rd_out), .rom_data_in(rom_data_in),
    .index_valid_out(index_valid_out), .index_ready_in(index_ready_in),
    .vertex_id_out(vertex_id_out), .material_out(material_out)
  );

  // Index ROM behaviour: data for a read appears LAT cycles after the read cycle.
  logic [23:0] rom_mem  [1 << AW];
  logic [23:0] rom_pipe [LAT];
  always @(posedge clk_in) begin
    rom_pipe[0] <= rom_rd_out ? rom_mem[rom_addr_out] : 24'h0;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data_in = rom_pipe[LAT-1];

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input longint actual, input longint required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < (1 << AW); i++)
      rom_mem[i] = {12'($urandom_range(0, 12'hFFE)), 12'($urandom)};
  endtask

  typedef struct {
    int base;
    int count;
    int ready_pct;
    int stall;
    bit extra_start;
    int plant;
    int first_rd;
    int first_valid;
    int done;
  } vec_t;

  task automatic run_draw(input vec_t v);
    logic [23:0]   exp_q[$];
    logic [23:0]   e;
    logic [AW-1:0] a, exp_addr;
    int issued, popped, first_rd, first_valid, done_cyc, term_ret;
    bit finished;
    issued = 0; popped = 0; first_rd = -1; first_valid = -1;
    done_cyc = -1; term_ret = NEVER; finished = 0;
    // Model: walk the ROM from base for count entries (stopping at a terminator when enabled).
    for (int i = 0; i < v.count; i++) begin
      a = AW'(v.base + i);
      e = rom_mem[a];
`ifdef FETCH_SEQ_TERMINATOR_EN
      if (e[23:12] == TERMINATOR_ID) break;
`endif
      exp_q.push_back(e);
    end
    exp_addr = AW'(v.base);
    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      start_in       = (cyc == 0) || (v.extra_start && cyc == 2);
      base_in        = (cyc == 0) ? AW'(v.base) : AW'(v.base + 7);
      count_in       = (cyc == 0) ? (AW+1)'(v.count) : (AW+1)'(3);
      index_ready_in = (v.stall > 0 && cyc <= v.stall) ? 1'b0 : ($urandom_range(0, 99) < v.ready_pct);
      if (rom_rd_out) begin
        if (first_rd < 0) first_rd = cyc;
        check("rd_addr", rom_addr_out, exp_addr);
        exp_addr = exp_addr + AW'(1);
        issued++;
        check("read_budget", issued <= v.count, 1);
        check("read_after_term", cyc > term_ret, 0);
        check("outstanding", (issued - popped) <= DEPTH, 1);
`ifdef FETCH_SEQ_TERMINATOR_EN
        if (term_ret == NEVER && rom_mem[rom_addr_out][23:12] == TERMINATOR_ID) term_ret = cyc + LAT;
`endif
      end
      if (index_valid_out && first_valid < 0) first_valid = cyc;
      if (index_valid_out && index_ready_in) begin
        check("entry_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("vertex_id", vertex_id_out, e[23:12]);
          check("material", material_out, e[11:0]);
        end
        popped++;
      end
      if (v.stall > 0 && cyc == v.stall) begin
        check("stall_reads", issued, (v.count < DEPTH) ? v.count : DEPTH);
        check("stall_rd_low", rom_rd_out, 0);
      end
      if (done_out) begin
        done_cyc = cyc;
        finished = 1;
        check("busy_at_done", busy_out, 0);
      end else if (cyc > 0) begin
        check("busy", busy_out, 1);
      end else begin
        check("idle_rd", rom_rd_out, 0);
      end
      @(posedge clk_in); #1;
    end
    start_in = 1'b0;
    check("done_seen", finished, 1);
    if (v.first_rd != DC)    check("first_rd_cycle", first_rd, v.first_rd);
    if (v.first_valid != DC) check("first_valid_cycle", first_valid, v.first_valid);
    if (v.done != DC)        check("done_cycle", done_cyc, v.done);
    check("entries_left", exp_q.size(), 0);
`ifndef FETCH_SEQ_TERMINATOR_EN
    check("reads_total", issued, v.count);
`endif
    check("done_pulse", done_out, 0);
    check("busy_after", busy_out, 0);
    check("valid_after", index_valid_out, 0);
    $display("draw base=%0d count=%0d ready_pct=%0d reads=%0d delivered=%0d done_at=%0d",
             v.base, v.count, v.ready_pct, issued, popped, done_cyc);
  endtask

  vec_t vecs[9];
  vec_t rv;

  initial begin
    rst_in = 1'b1; start_in = 1'b0; base_in = '0; count_in = '0; index_ready_in = 1'b0;
    fill_rom();
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_rd", rom_rd_out, 0);
    check("rst_addr", rom_addr_out, 0);
    check("rst_valid", index_valid_out, 0);
    check("rst_vertex", vertex_id_out, 0);
    check("rst_material", material_out, 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    //          base  cnt  rdy stall xs  plant rd  valid done
    vecs[0] = '{5,    3,   100, 0,  1'b0, -1,  1,  4,   7};
    vecs[1] = '{1022, 4,   100, 0,  1'b0, -1,  1,  4,   8};
    vecs[2] = '{100,  0,   100, 0,  1'b0, -1, -1, -1,   2};
    vecs[3] = '{200,  16,  100, 0,  1'b0, -1,  1,  4,  20};
    vecs[4] = '{400,  5,   100, 0,  1'b1, -1,  1,  4,   9};
    vecs[5] = '{500,  1,   100, 0,  1'b0, -1,  1,  4,   5};
    vecs[6] = '{300,  8,   100, 0,  1'b0,  3,  1,  4,  DC};
    vecs[7] = '{700,  16,  100, 20, 1'b0, -1,  1,  4,  DC};
    vecs[8] = '{600,  20,  50,  0,  1'b0, -1,  1,  4,  DC};
    for (int k = 0; k < 9; k++) begin
      fill_rom();
      if (vecs[k].plant >= 0) rom_mem[AW'(vecs[k].base + vecs[k].plant)][23:12] = TERMINATOR_ID;
      run_draw(vecs[k]);
    end

    // Reset in the middle of a draw.
    fill_rom();
    start_in = 1'b1; base_in = AW'(50); count_in = (AW+1)'(16); index_ready_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (6) @(posedge clk_in);
    #1;
    check("pre_reset_valid", index_valid_out, 1);
    rst_in = 1'b1;
    #1;
    check("reset_valid_now", index_valid_out, 0);
    check("reset_rd_now", rom_rd_out, 0);
    check("reset_busy_now", busy_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("post_reset_valid", index_valid_out, 0);
      check("post_reset_rd", rom_rd_out, 0);
      @(posedge clk_in); #1;
    end
    rv = '{60, 5, 100, 0, 1'b0, -1, 1, 4, 9};
    run_draw(rv);

    // Random draws.
    for (int k = 0; k < 25; k++) begin
      fill_rom();
      rv.base        = int'($urandom_range(0, (1 << AW) - 1));
      rv.count       = int'($urandom_range(0, 40));
      rv.ready_pct   = int'($urandom_range(20, 100));
      rv.stall       = 0;
      rv.extra_start = 1'($urandom_range(0, 1));
      rv.plant       = -1;
      rv.first_rd    = DC;
      rv.first_valid = DC;
      rv.done        = DC;
      run_draw(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
